// File: rtl/neuron_cfg_tx.sv
// neuron_cfg_tx: packs host bytes into PW-bit configuration words and writes
// them to a neuron config port as one threshold word followed by
// WORDS_PER_NEURON weight words per neuron.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start, s_ready low
// S_THRESH  | collecting the threshold word of the current neuron
// S_WEIGHTS | collecting weight words of the current neuron
// S_DONE    | one-cycle done pulse, then back to idle
module neuron_cfg_tx #(
    parameter int PW               = 16,
    parameter int THRESH_W         = 16,
    parameter int WORDS_PER_NEURON = 49,
    parameter int MAX_NEURONS      = 256,
    localparam int NUMW = $clog2(MAX_NEURONS + 1),
    localparam int NIW  = (MAX_NEURONS > 1) ? $clog2(MAX_NEURONS) : 1,
    localparam int WIW  = (WORDS_PER_NEURON > 1) ? $clog2(WORDS_PER_NEURON) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NUMW-1:0] num_neurons,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [7:0]      s_data,
    output logic            cfg_w_en,
    output logic [PW-1:0]   cfg_w_data,
    output logic            cfg_thresh_sel,
    output logic [NIW-1:0]  cfg_neuron_idx,
    output logic [WIW-1:0]  cfg_word_idx,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int BPW = PW / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_THRESH, S_WEIGHTS, S_DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NUMW-1:0] num_lat;
    logic [NIW-1:0]  neuron_cnt;
    logic [WIW-1:0]  word_cnt;
    logic [BCW-1:0]  byte_cnt;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   word_nxt;
    logic            hs;
    logic            word_done;
    logic            last_weight;
    logic            last_neuron;
    logic            start_ok;

    assign hs          = s_valid && s_ready;
    assign word_done   = hs && (byte_cnt == BCW'(BPW - 1));
    assign last_weight = (word_cnt == WIW'(WORDS_PER_NEURON - 1));
    assign last_neuron = (NUMW'(neuron_cnt) == (num_lat - NUMW'(1)));
    assign start_ok    = start && (state == S_IDLE);

    // Completed word: bytes already held in acc, final byte straight from the bus.
    always_comb begin
        word_nxt = acc;
        word_nxt[PW-1 -: 8] = s_data;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived handshake/status outputs.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (num_neurons == NUMW'(0)) ? S_DONE : S_THRESH;
                end
            end
            S_THRESH: begin
                s_ready = 1'b1;
                if (word_done) begin
                    state_nxt = S_WEIGHTS;
                end
            end
            S_WEIGHTS: begin
                s_ready = 1'b1;
                if (word_done && last_weight) begin
                    state_nxt = last_neuron ? S_DONE : S_THRESH;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Byte packing, word/neuron counters, write port registers and sticky err.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_lat        <= '0;
            neuron_cnt     <= '0;
            word_cnt       <= '0;
            byte_cnt       <= '0;
            acc            <= '0;
            cfg_w_en       <= 1'b0;
            cfg_w_data     <= '0;
            cfg_thresh_sel <= 1'b0;
            cfg_neuron_idx <= '0;
            cfg_word_idx   <= '0;
            err            <= 1'b0;
        end else begin
            cfg_w_en <= 1'b0;
            if (start_ok) begin
                num_lat    <= num_neurons;
                neuron_cnt <= '0;
                word_cnt   <= '0;
                byte_cnt   <= '0;
                err        <= 1'b0;
            end
            if (hs) begin
                acc[{byte_cnt, 3'b000} +: 8] <= s_data;
                byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
            end
            if (word_done) begin
                cfg_w_en       <= 1'b1;
                cfg_w_data     <= word_nxt;
                cfg_neuron_idx <= neuron_cnt;
                if (state == S_THRESH) begin
                    cfg_thresh_sel <= 1'b1;
                    cfg_word_idx   <= '0;
                    if ((word_nxt >> THRESH_W) != '0) begin
                        err <= 1'b1;
                    end
                end else begin
                    cfg_thresh_sel <= 1'b0;
                    cfg_word_idx   <= word_cnt;
                    if (last_weight) begin
                        word_cnt <= '0;
                        if (!last_neuron) begin
                            neuron_cnt <= neuron_cnt + 1'b1;
                        end
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule
